// File: rtl/dff_pipe_if.sv
// dff_pipe_if: producer/consumer handshake bundle for the dff_pipe register pipeline.
interface dff_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;

  // Pipeline side: takes producer data and consumer ready, drives the rest.
  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, q, count
  );

  // Environment side: producer and consumer combined.
  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, q, count
  );
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage WIDTH-bit delay line with per-stage valid bits,
// valid/ready flow control, bubble collapsing and an occupancy counter.
module dff_pipe #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           DEPTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic         c,
  input  logic         rst,
  dff_pipe_if.slave    bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic             free0;
  logic             accept;
  logic             take;
  logic [CW-1:0]    count_q;

  // Ready chain from the output back to stage 0: a stage advances when it is
  // valid and the stage ahead is either empty or advancing itself.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = v[i] & carry;
      carry  = ~v[i] | adv[i];
    end
    free0 = carry;
  end

  assign bus.in_ready = ~rst & free0;
  assign accept       = bus.in_valid & bus.in_ready;
  assign take         = adv[DEPTH-1];

  // Stage data/valid registers; data only loads when an item arrives.
  always_ff @(posedge c) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RESET_VAL;
      end
    end else begin
      if (accept) begin
        data[0] <= bus.d;
        v[0]    <= 1'b1;
      end else if (adv[0]) begin
        v[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) begin
          data[i] <= data[i-1];
          v[i]    <= 1'b1;
        end else if (adv[i]) begin
          v[i] <= 1'b0;
        end
      end
    end
  end

  // Occupancy counter tracking popcount(v) from accept/take events.
  always_ff @(posedge c) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept && !take) begin
      count_q <= count_q + CW'(1);
    end else if (take && !accept) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign bus.q         = data[DEPTH-1];
  assign bus.out_valid = v[DEPTH-1];
  assign bus.count     = count_q;
endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised register pipeline that generalises the single D flip-flop into a DEPTH-stage, WIDTH-bit delay line with per-stage valid bits. It adds valid/ready flow control with bubble collapsing and an occupancy count. It sits between producer and consumer blocks that need a fixed retiming latency and must tolerate consumer back-pressure without losing data. It is the drop-in replacement wherever a chain of plain flops was hand-instantiated.

## Interface
Parameters:
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 4, number of register stages (>= 1)
- RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits)

Ports:
- c  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous and active-high
- in_valid  input  1  producer offers d this cycle
- in_ready  output  1  pipeline accepts d this cycle
- d  input  WIDTH  input data
- out_valid  output  1  q holds a valid item
- out_ready  input  1  consumer takes q this cycle
- q  output  WIDTH  output data (stage DEPTH-1)
- count  output  $clog2(DEPTH+1)  number of valid items held, 0..DEPTH

## Operation
- State: DEPTH stages, each holding data[i] (WIDTH bits) and v[i] (1 bit). Stage 0 is the input stage. Stage DEPTH-1 drives q and out_valid.
- Advance terms (combinational):
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - For i < DEPTH-1: adv[i] = v[i] & (!v[i+1] | adv[i+1]).
  - Stage i is "free" when !v[i] | adv[i].
- in_ready = !rst & (!v[0] | adv[0]). Accept = in_valid & in_ready.
- Stage 0 update on accept: data[0] <= d, v[0] <= 1. Otherwise, if adv[0], v[0] <= 0.
- Stage i > 0 update:
  - If adv[i-1]: data[i] <= data[i-1], v[i] <= 1.
  - Else if adv[i]: v[i] <= 0.
  - Else hold.
- Bubble collapsing: a valid item moves forward whenever the next stage is empty, even while the output is stalled. The pipeline therefore fills completely before in_ready drops.
- Data registers load only when receiving an item. Empty stages keep stale data. q equals data[DEPTH-1] regardless of out_valid.
- count = popcount(v). Maintain it as a registered counter: +1 on accept without output take, -1 on output take without accept, unchanged otherwise. It must always equal popcount(v).
- Ordering is strictly FIFO. Items are never duplicated or dropped except by reset.
- The ready chain is combinational across all DEPTH stages by design. No skid buffer.

## Timing
- Reset (rst high at a rising edge):
  - next cycle: all v = 0, all data = RESET_VAL, q = RESET_VAL, out_valid = 0, count = 0.
  - in_ready = 0 while rst is high. in_valid is ignored during reset.
- First cycle after rst deasserts: in_ready = 1.
- Latency: an item accepted at edge N into an empty, unstalled pipe appears with out_valid = 1 after edge N+DEPTH-1. That is, it is visible at q DEPTH cycles after presentation at d, counting the accept edge.
- Throughput: 1 item/cycle sustained when out_ready = 1.
- Full pipe (count = DEPTH), out_ready = 0: in_ready = 0, all state holds.
- Full pipe, out_ready = 1, in_valid = 1, same cycle: output taken, input accepted, all stages shift, count stays DEPTH.
- Empty pipe, out_ready = 1: out_valid = 0, nothing taken, count = 0.
- Reset mid-operation: all in-flight items are discarded at the reset edge. No item emerges afterwards.
- DEPTH = 1: degenerates to a single registered valid/ready stage. in_ready = !v[0] | out_ready.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'hA5, hold rst 2 cycles -> q=8'hA5, out_valid=0, count=0, in_ready=0 during rst and 1 after.
- Streaming: out_ready=1, feed 0x01..0x10 back-to-back -> 0x01 at q with out_valid after exactly 4 cycles, then one item per cycle in order; count steady at 4.
- Back-pressure fill: out_ready=0, feed 0x11,0x22,0x33,0x44,0x55 -> first four accepted, in_ready=0 on the fifth, count=4. Then out_ready=1 -> 0x11..0x55 emerge in order.
- Bubble collapse: send 0x01, idle 2 cycles, send 0x02, out_ready=0 -> items compact into stages 3 and 2, count=2, in_ready stays 1.
- Simultaneous take/accept on full pipe: count=4, in_valid=1 with 0x99, out_ready=1 -> head item leaves, 0x99 enters, count remains 4.
- Reset mid-stream: count=3, assert rst one cycle -> count=0, out_valid=0, q=RESET_VAL, no stale item ever emerges.
